// File: rtl/i2c_target_pkg.sv
// Shared types for the I2C target: FSM state encoding and the R/W bit position
// within the address byte.
package i2c_target_pkg;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_ADDR     = 4'd1,
    S_ADDR_ACK = 4'd2,
    S_PTR      = 4'd3,
    S_PTR_ACK  = 4'd4,
    S_WR       = 4'd5,
    S_WR_ACK   = 4'd6,
    S_RD       = 4'd7,
    S_RD_ACK   = 4'd8,
    S_IGNORE   = 4'd9
  } state_t;

  localparam int RW_BIT = 0;

endpackage

// File: rtl/i2c_target_cond.sv
// SCL/SDA conditioning: 2-FF synchronizers, optional stable-sample filter
// (I2C_TGT_FILTER_EN), and SCL edge / START / STOP event generation.
module i2c_target_cond #(
  parameter int FILT_LEN = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop
);

  logic [1:0] scl_sync, sda_sync;
  logic       scl_f, sda_f, scl_q, sda_q;

  // Idle bus is high, so reset the pipeline high to avoid phantom events
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
    end else begin
      scl_sync <= {scl_sync[0], scl_i};
      sda_sync <= {sda_sync[0], sda_i};
    end
  end

`ifdef I2C_TGT_FILTER_EN
  localparam int CW = $clog2(FILT_LEN + 1);
  logic [1:0]    raw, filt;
  logic [CW-1:0] cnt [2];

  assign raw = {sda_sync[1], scl_sync[1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt   <= 2'b11;
      cnt[0] <= '0;
      cnt[1] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (raw[i] == filt[i]) cnt[i] <= '0;
        else if (cnt[i] == CW'(FILT_LEN - 1)) begin
          filt[i] <= raw[i];
          cnt[i]  <= '0;
        end else cnt[i] <= cnt[i] + CW'(1);
      end
    end
  end

  assign scl_f = filt[0];
  assign sda_f = filt[1];
`else
  logic unused_filt;
  assign unused_filt = (FILT_LEN != 0);
  assign scl_f = scl_sync[1];
  assign sda_f = sda_sync[1];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_q <= 1'b1;
      sda_q <= 1'b1;
    end else begin
      scl_q <= scl_f;
      sda_q <= sda_f;
    end
  end

  assign sda      = sda_f;
  assign scl_rise = scl_f & ~scl_q;
  assign scl_fall = ~scl_f & scl_q;
  assign start    = scl_f & scl_q & ~sda_f & sda_q;
  assign stop     = scl_f & scl_q & sda_f & ~sda_q;

endmodule

// File: rtl/i2c_target.sv
// I2C target exposing an 8-bit register window at a fixed 7-bit address.
// Define I2C_TGT_FILTER_EN to add the glitch filter in i2c_target_cond.
module i2c_target
  import i2c_target_pkg::*;
#(
  parameter logic [6:0] ADDR     = 7'h42,
  parameter int         AW       = 8,
  parameter int         FILT_LEN = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          scl_i,
  input  logic          sda_i,
  output logic          sda_oe,
  output logic [AW-1:0] reg_addr,
  output logic [7:0]    reg_wdata,
  output logic          reg_we,
  input  logic [7:0]    reg_rdata,
  output logic          reg_re,
  output logic          busy
);

  // state    | meaning
  // IDLE     | bus free or not yet addressed
  // ADDR     | shifting in address + R/W
  // ADDR_ACK | driving ACK for our address
  // PTR      | shifting in register pointer
  // PTR_ACK  | driving ACK for pointer
  // WR       | shifting in write data
  // WR_ACK   | driving ACK for write data
  // RD       | driving read data bits
  // RD_ACK   | sampling controller ACK/NACK
  // IGNORE   | not ours / read ended; wait for START or STOP

  logic sda, scl_rise, scl_fall, start, stop;

  i2c_target_cond #(.FILT_LEN(FILT_LEN)) u_cond (
    .clk      (clk),
    .rst_n    (rst_n),
    .scl_i    (scl_i),
    .sda_i    (sda_i),
    .sda      (sda),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start    (start),
    .stop     (stop)
  );

  state_t        state, state_nxt;
  logic [2:0]    bit_cnt, bit_cnt_nxt;
  logic [7:0]    shift, shift_nxt, byte_in;
  logic [AW-1:0] reg_addr_nxt;
  logic [7:0]    reg_wdata_nxt;
  logic          reg_we_nxt, reg_re_nxt, sda_oe_nxt, busy_nxt, mack, mack_nxt;

  assign byte_in = {shift[6:0], sda};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      bit_cnt   <= '0;
      shift     <= '0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      reg_we    <= 1'b0;
      reg_re    <= 1'b0;
      sda_oe    <= 1'b0;
      busy      <= 1'b0;
      mack      <= 1'b1;
    end else begin
      state     <= state_nxt;
      bit_cnt   <= bit_cnt_nxt;
      shift     <= shift_nxt;
      reg_addr  <= reg_addr_nxt;
      reg_wdata <= reg_wdata_nxt;
      reg_we    <= reg_we_nxt;
      reg_re    <= reg_re_nxt;
      sda_oe    <= sda_oe_nxt;
      busy      <= busy_nxt;
      mack      <= mack_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    bit_cnt_nxt   = bit_cnt;
    shift_nxt     = shift;
    reg_addr_nxt  = reg_addr;
    reg_wdata_nxt = reg_wdata;
    reg_we_nxt    = 1'b0;
    reg_re_nxt    = 1'b0;
    sda_oe_nxt    = sda_oe;
    busy_nxt      = busy;
    mack_nxt      = mack;

    // Post-write pointer advance lands the cycle after the strobe
    if (reg_we) reg_addr_nxt = reg_addr + AW'(1);

    if (start) begin
      state_nxt   = S_ADDR;
      bit_cnt_nxt = '0;
      sda_oe_nxt  = 1'b0;
      busy_nxt    = 1'b0;
    end else if (stop) begin
      state_nxt   = S_IDLE;
      bit_cnt_nxt = '0;
      sda_oe_nxt  = 1'b0;
      busy_nxt    = 1'b0;
    end else begin
      case (state)
        S_ADDR, S_PTR, S_WR: begin
          if (scl_rise) begin
            shift_nxt   = byte_in;
            bit_cnt_nxt = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              if (state == S_ADDR) begin
                if (byte_in[7:1] == ADDR) begin
                  state_nxt = S_ADDR_ACK;
                  busy_nxt  = 1'b1;
                end else state_nxt = S_IGNORE;
              end else if (state == S_PTR) begin
                reg_addr_nxt = byte_in[AW-1:0];
                state_nxt    = S_PTR_ACK;
              end else begin
                reg_wdata_nxt = byte_in;
                reg_we_nxt    = 1'b1;
                state_nxt     = S_WR_ACK;
              end
            end
          end
        end
        // First fall drives ACK low, the next fall ends the ACK bit
        S_ADDR_ACK, S_PTR_ACK, S_WR_ACK: begin
          if (scl_fall) begin
            if (!sda_oe) sda_oe_nxt = 1'b1;
            else begin
              sda_oe_nxt  = 1'b0;
              bit_cnt_nxt = '0;
              if (state == S_ADDR_ACK && shift[RW_BIT]) begin
                shift_nxt    = reg_rdata;
                sda_oe_nxt   = ~reg_rdata[7];
                reg_re_nxt   = 1'b1;
                reg_addr_nxt = reg_addr + AW'(1);
                state_nxt    = S_RD;
              end else if (state == S_ADDR_ACK) state_nxt = S_PTR;
              else state_nxt = S_WR;
            end
          end
        end
        S_RD: begin
          if (scl_fall) begin
            if (bit_cnt == 3'd7) begin
              sda_oe_nxt  = 1'b0;
              bit_cnt_nxt = '0;
              state_nxt   = S_RD_ACK;
            end else begin
              shift_nxt   = {shift[6:0], shift[7]};
              sda_oe_nxt  = ~shift[6];
              bit_cnt_nxt = bit_cnt + 3'd1;
            end
          end
        end
        S_RD_ACK: begin
          if (scl_rise) mack_nxt = sda;
          if (scl_fall) begin
            if (!mack) begin
              shift_nxt    = reg_rdata;
              sda_oe_nxt   = ~reg_rdata[7];
              reg_re_nxt   = 1'b1;
              reg_addr_nxt = reg_addr + AW'(1);
              state_nxt    = S_RD;
            end else state_nxt = S_IGNORE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: bit-banged controller on an open-drain bus,
// registered CSR model, strobe monitor.
`timescale 1ns/1ps
module tb_i2c_target;

  localparam int Q = 100;

  logic       clk = 1'b0, rst_n = 1'b1, scl_m = 1'b1, sda_m = 1'b1;
  logic       scl_i, sda_i, sda_oe, reg_we, reg_re, busy;
  logic [7:0] reg_addr, reg_wdata, reg_rdata;
  logic [7:0] mem [256];

  int         errors = 0, checks = 0;
  int         we_n, re_n;
  logic [7:0] wa [8];
  logic [7:0] wd [8];
  logic       oe_seen, busy_seen;

  always #5 clk = ~clk;

  assign scl_i = scl_m;
  assign sda_i = sda_m & ~sda_oe;

  i2c_target dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .scl_i     (scl_i),
    .sda_i     (sda_i),
    .sda_oe    (sda_oe),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_we    (reg_we),
    .reg_rdata (reg_rdata),
    .reg_re    (reg_re),
    .busy      (busy)
  );

  always @(posedge clk) reg_rdata <= mem[reg_addr];

  always @(negedge clk) begin
    if (rst_n) begin
      if (reg_we) begin
        if (we_n < 8) begin
          wa[we_n] = reg_addr;
          wd[we_n] = reg_wdata;
        end
        we_n++;
      end
      if (reg_re) re_n++;
      if (sda_oe) oe_seen = 1'b1;
      if (busy) busy_seen = 1'b1;
    end
  end

  task automatic clear_mon();
    for (int i = 0; i < 8; i++) begin
      wa[i] = 'x;
      wd[i] = 'x;
    end
    we_n = 0; re_n = 0; oe_seen = 1'b0; busy_seen = 1'b0;
  endtask

  task automatic bit_io(input logic b, input logic glitch, output logic r);
    sda_m = b;
    #Q scl_m = 1'b1;
    if (glitch) begin
      #40 sda_m = 1'b0;
      #10 sda_m = 1'b1;
      #50;
    end else #Q;
    r = sda_i;
    #Q scl_m = 1'b0;
    #Q;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gbit, output logic ack);
    logic r;
    for (int i = 0; i < 8; i++) bit_io(b[7-i], i == gbit, r);
    bit_io(1'b1, 1'b0, ack);
  endtask

  task automatic recv_byte(input logic ack_out, output logic [7:0] d);
    logic r;
    d = '0;
    for (int i = 0; i < 8; i++) begin
      bit_io(1'b1, 1'b0, r);
      d = {d[6:0], r};
    end
    bit_io(ack_out, 1'b0, r);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1;
    #Q scl_m = 1'b1;
    #Q sda_m = 1'b0;
    #Q scl_m = 1'b0;
    #Q;
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0;
    #Q scl_m = 1'b1;
    #Q sda_m = 1'b1;
    #Q;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #20;
    checks++; if (sda_oe !== 1'b0) begin errors++; $display("FAIL reset_sda_oe got=%b exp=0", sda_oe); end
    checks++; if (reg_we !== 1'b0) begin errors++; $display("FAIL reset_reg_we got=%b exp=0", reg_we); end
    checks++; if (reg_re !== 1'b0) begin errors++; $display("FAIL reset_reg_re got=%b exp=0", reg_re); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (reg_addr !== 8'h00) begin errors++; $display("FAIL reset_reg_addr got=%h exp=00", reg_addr); end
    checks++; if (reg_wdata !== 8'h00) begin errors++; $display("FAIL reset_reg_wdata got=%h exp=00", reg_wdata); end
    @(negedge clk) rst_n = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_write();
    logic a0, a1, a2, a3;
    clear_mon();
    i2c_start();
    send_byte(8'h84, 8, a0);
    checks++; if (a0 !== 1'b0) begin errors++; $display("FAIL wr_addr_ack got=%b exp=0", a0); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL wr_busy got=%b exp=1", busy); end
    send_byte(8'h10, 8, a1);
    send_byte(8'hA5, 8, a2);
    send_byte(8'h5A, 8, a3);
    checks++; if ({a1, a2, a3} !== 3'b000) begin errors++; $display("FAIL wr_data_acks got=%b exp=000", {a1, a2, a3}); end
    i2c_stop();
    repeat (5) @(negedge clk);
    checks++; if (we_n !== 2) begin errors++; $display("FAIL wr_we_count got=%0d exp=2", we_n); end
    checks++; if (wa[0] !== 8'h10 || wd[0] !== 8'hA5) begin errors++; $display("FAIL wr_first got=%h/%h exp=10/a5", wa[0], wd[0]); end
    checks++; if (wa[1] !== 8'h11 || wd[1] !== 8'h5A) begin errors++; $display("FAIL wr_second got=%h/%h exp=11/5a", wa[1], wd[1]); end
    checks++; if (reg_addr !== 8'h12) begin errors++; $display("FAIL wr_ptr_after got=%h exp=12", reg_addr); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wr_busy_after_stop got=%b exp=0", busy); end
  endtask

  task automatic test_read_rs();
    logic a0, a1, a2;
    logic [7:0] d0, d1, d2;
    mem[8'h20] = 8'hC3;
    mem[8'h21] = 8'h3C;
    clear_mon();
    i2c_start();
    send_byte(8'h84, 8, a0);
    send_byte(8'h20, 8, a1);
    i2c_start();
    send_byte(8'h85, 8, a2);
    checks++; if ({a0, a1, a2} !== 3'b000) begin errors++; $display("FAIL rd_acks got=%b exp=000", {a0, a1, a2}); end
    recv_byte(1'b0, d0);
    recv_byte(1'b1, d1);
    recv_byte(1'b1, d2);
    i2c_stop();
    repeat (5) @(negedge clk);
    checks++; if (d0 !== 8'hC3) begin errors++; $display("FAIL rd_byte0 got=%h exp=c3", d0); end
    checks++; if (d1 !== 8'h3C) begin errors++; $display("FAIL rd_byte1 got=%h exp=3c", d1); end
    checks++; if (d2 !== 8'hFF) begin errors++; $display("FAIL rd_after_nack got=%h exp=ff", d2); end
    checks++; if (re_n !== 2) begin errors++; $display("FAIL rd_re_count got=%0d exp=2", re_n); end
    checks++; if (we_n !== 0) begin errors++; $display("FAIL rd_we_count got=%0d exp=0", we_n); end
    checks++; if (reg_addr !== 8'h22) begin errors++; $display("FAIL rd_ptr_after got=%h exp=22", reg_addr); end
  endtask

  task automatic test_wrong_addr();
    logic a0, a1;
    clear_mon();
    i2c_start();
    send_byte(8'h90, 8, a0);
    send_byte(8'h00, 8, a1);
    i2c_stop();
    repeat (5) @(negedge clk);
    checks++; if ({a0, a1} !== 2'b11) begin errors++; $display("FAIL wa_nack got=%b exp=11", {a0, a1}); end
    checks++; if (oe_seen !== 1'b0) begin errors++; $display("FAIL wa_sda_oe got=%b exp=0", oe_seen); end
    checks++; if (busy_seen !== 1'b0) begin errors++; $display("FAIL wa_busy got=%b exp=0", busy_seen); end
    checks++; if (we_n + re_n !== 0) begin errors++; $display("FAIL wa_strobes got=%0d exp=0", we_n + re_n); end
  endtask

  task automatic test_wrap();
    logic a0, a1, a2, a3;
    clear_mon();
    i2c_start();
    send_byte(8'h84, 8, a0);
    send_byte(8'hFF, 8, a1);
    send_byte(8'h11, 8, a2);
    send_byte(8'h22, 8, a3);
    i2c_stop();
    repeat (5) @(negedge clk);
    checks++; if ({a0, a1, a2, a3} !== 4'b0000) begin errors++; $display("FAIL wrap_acks got=%b exp=0000", {a0, a1, a2, a3}); end
    checks++; if (wa[0] !== 8'hFF || wd[0] !== 8'h11) begin errors++; $display("FAIL wrap_first got=%h/%h exp=ff/11", wa[0], wd[0]); end
    checks++; if (wa[1] !== 8'h00 || wd[1] !== 8'h22) begin errors++; $display("FAIL wrap_second got=%h/%h exp=00/22", wa[1], wd[1]); end
    checks++; if (reg_addr !== 8'h01) begin errors++; $display("FAIL wrap_ptr_after got=%h exp=01", reg_addr); end
  endtask

  task automatic test_partial_stop();
    logic a0, a1, a2, r;
    logic [4:0] bits;
    bits = 5'b10110;
    clear_mon();
    i2c_start();
    send_byte(8'h84, 8, a0);
    send_byte(8'h30, 8, a1);
    for (int i = 4; i >= 0; i--) bit_io(bits[i], 1'b0, r);
    i2c_stop();
    repeat (5) @(negedge clk);
    checks++; if (we_n !== 0) begin errors++; $display("FAIL partial_we got=%0d exp=0", we_n); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL partial_busy got=%b exp=0", busy); end
    checks++; if (reg_addr !== 8'h30) begin errors++; $display("FAIL partial_ptr got=%h exp=30", reg_addr); end
    i2c_start();
    send_byte(8'h84, 8, a0);
    send_byte(8'h40, 8, a1);
    send_byte(8'h77, 8, a2);
    i2c_stop();
    repeat (5) @(negedge clk);
    checks++; if (a2 !== 1'b0) begin errors++; $display("FAIL partial_next_ack got=%b exp=0", a2); end
    checks++; if (we_n !== 1 || wa[0] !== 8'h40 || wd[0] !== 8'h77) begin
      errors++; $display("FAIL partial_next_write got=%0d %h/%h exp=1 40/77", we_n, wa[0], wd[0]);
    end
  endtask

  task automatic test_reset_mid_rd();
    logic a0, a1, a2;
    mem[8'h50] = 8'h00;
    clear_mon();
    i2c_start();
    send_byte(8'h84, 8, a0);
    send_byte(8'h50, 8, a1);
    i2c_start();
    send_byte(8'h85, 8, a2);
    checks++; if (sda_oe !== 1'b1) begin errors++; $display("FAIL rst_rd_driving got=%b exp=1", sda_oe); end
    #3 rst_n = 1'b0;
    #1;
    checks++; if (sda_oe !== 1'b0) begin errors++; $display("FAIL rst_rd_sda_oe got=%b exp=0", sda_oe); end
    checks++; if ({reg_we, reg_re, busy} !== 3'b000) begin errors++; $display("FAIL rst_rd_flags got=%b exp=000", {reg_we, reg_re, busy}); end
    checks++; if (reg_addr !== 8'h00 || reg_wdata !== 8'h00) begin
      errors++; $display("FAIL rst_rd_regs got=%h/%h exp=00/00", reg_addr, reg_wdata);
    end
    scl_m = 1'b1;
    sda_m = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
  endtask

`ifdef I2C_TGT_FILTER_EN
  task automatic test_glitch();
    logic a0, a1, a2;
    clear_mon();
    i2c_start();
    send_byte(8'h84, 8, a0);
    send_byte(8'h60, 8, a1);
    send_byte(8'h81, 0, a2);
    i2c_stop();
    repeat (5) @(negedge clk);
    checks++; if ({a0, a1, a2} !== 3'b000) begin errors++; $display("FAIL glitch_acks got=%b exp=000", {a0, a1, a2}); end
    checks++; if (we_n !== 1 || wa[0] !== 8'h60 || wd[0] !== 8'h81) begin
      errors++; $display("FAIL glitch_write got=%0d %h/%h exp=1 60/81", we_n, wa[0], wd[0]);
    end
  endtask
`endif

  initial begin
    #800000;
    $display("FAIL timeout: bench did not finish");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    clear_mon();
    test_reset();
    test_write();
    test_read_rs();
    test_wrong_addr();
    test_wrap();
    test_partial_stop();
`ifdef I2C_TGT_FILTER_EN
    test_glitch();
`endif
    test_reset_mid_rd();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
